// File: rtl/uarr_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : uarr_wbuf
// Description : Banked dual-port weight buffer with a strided burst reader.
//               Every burst beat reads address a on port A and a+1 on port B
//               of all banks. Data passes through a one-stage read pipeline
//               into a small skid FIFO that presents it on a valid/ready
//               output. Writes use port B and take priority over reads.
//               Optional macro UARR_WBUF_OUTREG_EN adds a register stage
//               after the banks: read latency 2 and skid depth 3.
// Revision    : 1.0 - initial release
// ============================================================================
module uarr_wbuf #(
  parameter int NBANK  = 16,
  parameter int DW     = 32,
  parameter int AW     = 8,
  parameter int STRIDE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(NBANK)-1:0]   wr_bank,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AW-1:0]              req_base,
  input  logic [AW-1:0]              req_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [2*NBANK-1:0][DW-1:0] out_data,
  output logic                       busy
);

`ifdef UARR_WBUF_OUTREG_EN
  localparam logic [2:0] c_DEPTH = 3'd3;
`else
  localparam logic [2:0] c_DEPTH = 3'd2;
`endif

  typedef logic [2*NBANK-1:0][DW-1:0] beat_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DW-1:0]       r_mem [NBANK][2**AW];
  logic [AW-1:0]       r_addr, r_idx, r_len;
  logic [AW-1:0]       w_addr_b;
  beat_t               r_rd_data;
  logic                r_rd_vld, r_rd_last;
  beat_t               w_push_data;
  logic                w_push, w_push_last;
  beat_t               r_fifo [c_DEPTH];
  logic [c_DEPTH-1:0]  r_fifo_last;
  logic [2:0]          r_count, w_infl, w_wpos;
  logic                w_pop, w_credit, w_issue, w_accept;

  assign w_addr_b  = r_addr + AW'(1);
  assign out_valid = (r_count != 3'd0);
  assign out_data  = r_fifo[0];
  assign out_last  = r_fifo_last[0];
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_pop     = out_valid && out_ready;
  assign w_wpos    = r_count - {2'b0, w_pop};
  // Credit counts this cycle's pop so a full pipeline still issues one beat
  // per cycle; the FIFO can never overflow because space is reserved at issue.
  assign w_credit  = ((r_count + w_infl) - {2'b0, w_pop}) < c_DEPTH;

  // Next-state and burst issue decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_credit && !wr_en) begin
          w_issue = 1'b1;
          if (r_idx == r_len) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && out_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM, burst address/beat counters and read-valid pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= req_base;
        r_idx  <= '0;
        r_len  <= req_len;
      end else if (w_issue) begin
        r_addr <= r_addr + AW'(STRIDE);
        r_idx  <= r_idx + AW'(1);
      end
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue && (r_idx == r_len);
    end
  end

  // Bank storage: port B write (priority), port A/B burst read; never reset
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_bank][wr_addr] <= wr_data;
    if (w_issue) begin
      for (int k = 0; k < NBANK; k++) begin
        r_rd_data[2*k]   <= r_mem[k][r_addr];
        r_rd_data[2*k+1] <= r_mem[k][w_addr_b];
      end
    end
  end

`ifdef UARR_WBUF_OUTREG_EN
  beat_t r_st2_data;
  logic  r_st2_vld, r_st2_last;

  // Output register stage control after the banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st2_vld  <= 1'b0;
      r_st2_last <= 1'b0;
    end else begin
      r_st2_vld  <= r_rd_vld;
      r_st2_last <= r_rd_last;
    end
  end

  // Output register stage data
  always_ff @(posedge clk) begin
    r_st2_data <= r_rd_data;
  end

  assign w_push      = r_st2_vld;
  assign w_push_data = r_st2_data;
  assign w_push_last = r_st2_last;
  assign w_infl      = {2'b0, r_rd_vld} + {2'b0, r_st2_vld};
`else
  assign w_push      = r_rd_vld;
  assign w_push_data = r_rd_data;
  assign w_push_last = r_rd_last;
  assign w_infl      = {2'b0, r_rd_vld};
`endif

  // Skid FIFO: entry 0 is the head; pop shifts down, push lands after survivors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_fifo_last <= '0;
      for (int i = 0; i < int'(c_DEPTH); i++) r_fifo[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < int'(c_DEPTH) - 1; i++) begin
          r_fifo[i]      <= r_fifo[i+1];
          r_fifo_last[i] <= r_fifo_last[i+1];
        end
      end
      if (w_push) begin
        for (int i = 0; i < int'(c_DEPTH); i++) begin
          if (w_wpos == 3'(i)) begin
            r_fifo[i]      <= w_push_data;
            r_fifo_last[i] <= w_push_last;
          end
        end
      end
      r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
    end
  end

endmodule
`default_nettype wire
